// File: rtl/external_interrupt_gateway.sv
// External interrupt gateway: per-source edge/level gating, fixed-priority
// arbitration (lowest ID wins), and claim/complete bookkeeping feeding MEIP.
module external_interrupt_gateway #(
  parameter int unsigned NUM_SOURCES = 8,
  parameter int unsigned CODE_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] irqIn,
  input  logic                   regWE,
  input  logic [1:0]             regAddr,
  input  logic [NUM_SOURCES-1:0] regWriteData,
  output logic [NUM_SOURCES-1:0] regReadData,
  input  logic                   claimReq,
  output logic                   claimValid,
  output logic [CODE_WIDTH-1:0]  claimId,
  input  logic                   completeReq,
  input  logic [CODE_WIDTH-1:0]  completeId,
  output logic                   externalInterrupt,
  output logic [CODE_WIDTH-1:0]  externalInterruptCode
);

  logic [NUM_SOURCES-1:0] enable, edgeMode, pending, inService, irqPrev;
  logic [NUM_SOURCES-1:0] eligible, winMask, claimMask, completeMask;
  logic [NUM_SOURCES-1:0] riseDet, levelSet, pendingNext, inServiceNext;
  logic [CODE_WIDTH-1:0]  winId;

  assign eligible = pending & enable & ~inService;

  // Scan from the highest ID down so the lowest eligible ID is left standing.
  always_comb begin
    winId   = '0;
    winMask = '0;
    for (int unsigned i = NUM_SOURCES; i > 0; i--) begin
      if (eligible[i-1]) begin
        winId        = CODE_WIDTH'(i);
        winMask      = '0;
        winMask[i-1] = 1'b1;
      end
    end
  end

  always_comb begin
    completeMask = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      completeMask[i] = completeReq && inService[i] &&
                        (completeId == CODE_WIDTH'(i + 1));
    end
  end

  assign claimMask = claimReq ? winMask : '0;
  assign riseDet   = irqIn & ~irqPrev;
  assign levelSet  = irqIn & ~inService & ~claimMask;

  // Edge rises are OR'd in after the claim clear so a concurrent rise wins.
  assign pendingNext   = (pending & ~claimMask) | (edgeMode & riseDet) |
                         (~edgeMode & levelSet);
  assign inServiceNext = (inService & ~completeMask) | claimMask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable                <= '0;
      edgeMode              <= '0;
      pending               <= '0;
      inService             <= '0;
      irqPrev               <= '0;
      claimValid            <= 1'b0;
      claimId               <= '0;
      externalInterrupt     <= 1'b0;
      externalInterruptCode <= '0;
    end else begin
      pending               <= pendingNext;
      inService             <= inServiceNext;
      irqPrev               <= irqIn;
      claimValid            <= claimReq;
      externalInterrupt     <= |eligible;
      externalInterruptCode <= winId;
      if (claimReq) claimId <= winId;
      if (regWE && regAddr == 2'd0) enable   <= regWriteData;
      if (regWE && regAddr == 2'd1) edgeMode <= regWriteData;
    end
  end

  always_comb begin
    regReadData = '0;
    case (regAddr)
      2'd0:    regReadData = enable;
      2'd1:    regReadData = edgeMode;
      2'd2:    regReadData = pending;
      default: regReadData = inService;
    endcase
  end

endmodule

// File: tb/tb_external_interrupt_gateway.sv
// Testbench for external_interrupt_gateway: directed scenarios plus a
// randomized run checked against a per-source behavioural model.
module tb_external_interrupt_gateway;
  localparam int NS = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] irqIn = '0;
  logic          regWE = 1'b0;
  logic [1:0]    regAddr = '0;
  logic [NS-1:0] regWriteData = '0;
  logic [NS-1:0] regReadData;
  logic          claimReq = 1'b0;
  logic          claimValid;
  logic [CW-1:0] claimId;
  logic          completeReq = 1'b0;
  logic [CW-1:0] completeId = '0;
  logic          externalInterrupt;
  logic [CW-1:0] externalInterruptCode;

  int total = 0;
  int bad   = 0;

  external_interrupt_gateway #(.NUM_SOURCES(NS), .CODE_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .irqIn(irqIn), .regWE(regWE), .regAddr(regAddr),
    .regWriteData(regWriteData), .regReadData(regReadData),
    .claimReq(claimReq), .claimValid(claimValid), .claimId(claimId),
    .completeReq(completeReq), .completeId(completeId),
    .externalInterrupt(externalInterrupt),
    .externalInterruptCode(externalInterruptCode)
  );

  always #5 clk = ~clk;

  // Reference model, indexed by source ID 1..NS.
  bit mEn[1:NS], mEdge[1:NS], mPend[1:NS], mSvc[1:NS], mPrev[1:NS];
  bit mClaimValid, mExt;
  int mClaimId, mCode;

  function automatic void modelReset();
    for (int id = 1; id <= NS; id++) begin
      mEn[id] = 0; mEdge[id] = 0; mPend[id] = 0; mSvc[id] = 0; mPrev[id] = 0;
    end
    mClaimValid = 0; mExt = 0; mClaimId = 0; mCode = 0;
  endfunction

  function automatic logic [NS-1:0] modelReg(input logic [1:0] a);
    logic [NS-1:0] v = '0;
    for (int id = 1; id <= NS; id++)
      v[id-1] = (a == 0) ? mEn[id] : (a == 1) ? mEdge[id] : (a == 2) ? mPend[id] : mSvc[id];
    return v;
  endfunction

  function automatic void modelStep();
    int win = 0;
    int claimed;
    int cid = int'(completeId);
    bit compOk;
    bit nPend[1:NS];
    bit nSvc[1:NS];
    bit irq, rise;
    for (int id = NS; id >= 1; id--)
      if (mPend[id] && mEn[id] && !mSvc[id]) win = id;
    claimed = claimReq ? win : 0;
    compOk = completeReq && cid >= 1 && cid <= NS && mSvc[cid];
    for (int id = 1; id <= NS; id++) begin
      irq  = irqIn[id-1];
      rise = irq && !mPrev[id];
      nPend[id] = mPend[id];
      if (id == claimed) nPend[id] = 0;
      if (mEdge[id]) begin
        if (rise) nPend[id] = 1;
      end else if (irq && !mSvc[id] && id != claimed) begin
        nPend[id] = 1;
      end
      nSvc[id] = mSvc[id];
      if (compOk && id == cid) nSvc[id] = 0;
      if (id == claimed) nSvc[id] = 1;
    end
    for (int id = 1; id <= NS; id++) begin
      mPend[id] = nPend[id];
      mSvc[id]  = nSvc[id];
      mPrev[id] = irqIn[id-1];
      if (regWE && regAddr == 2'd0) mEn[id]   = regWriteData[id-1];
      if (regWE && regAddr == 2'd1) mEdge[id] = regWriteData[id-1];
    end
    mExt = (win != 0);
    mCode = win;
    mClaimValid = claimReq;
    if (claimReq) mClaimId = claimed;
  endfunction

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    irqIn = '0; regWE = 1'b0; regAddr = '0; regWriteData = '0;
    claimReq = 1'b0; completeReq = 1'b0; completeId = '0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [NS-1:0] d);
    regWE = 1'b1; regAddr = a; regWriteData = d;
    cycle();
    regWE = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    total++; if (claimValid !== 1'b0) begin bad++; $display("FAIL reset_claimValid got=%0h exp=0", claimValid); end
    total++; if (claimId !== 4'd0) begin bad++; $display("FAIL reset_claimId got=%0h exp=0", claimId); end
    total++; if (externalInterrupt !== 1'b0) begin bad++; $display("FAIL reset_ext got=%0h exp=0", externalInterrupt); end
    total++; if (externalInterruptCode !== 4'd0) begin bad++; $display("FAIL reset_code got=%0h exp=0", externalInterruptCode); end
    for (int a = 0; a < 4; a++) begin
      regAddr = 2'(a); #1;
      total++; if (regReadData !== 8'h00) begin bad++; $display("FAIL reset_reg%0d got=%0h exp=0", a, regReadData); end
    end
  endtask

  task automatic test_edge_pulse();
    doReset();
    writeReg(2'd0, 8'h01);
    writeReg(2'd1, 8'h01);
    irqIn = 8'h01;
    cycle();
    irqIn = 8'h00;
    regAddr = 2'd2; #1;
    total++; if (regReadData !== 8'h01) begin bad++; $display("FAIL edge_pending got=%0h exp=01", regReadData); end
    total++; if (externalInterrupt !== 1'b0) begin bad++; $display("FAIL edge_ext_early got=%0h exp=0", externalInterrupt); end
    cycle();
    total++; if (externalInterrupt !== 1'b1) begin bad++; $display("FAIL edge_ext got=%0h exp=1", externalInterrupt); end
    total++; if (externalInterruptCode !== 4'd1) begin bad++; $display("FAIL edge_code got=%0h exp=1", externalInterruptCode); end
  endtask

  task automatic test_claim_level();
    doReset();
    writeReg(2'd0, 8'hFF);
    irqIn = 8'h14;
    cycle(); cycle();
    claimReq = 1'b1;
    cycle();
    total++; if (claimValid !== 1'b1) begin bad++; $display("FAIL claim1_valid got=%0h exp=1", claimValid); end
    total++; if (claimId !== 4'd3) begin bad++; $display("FAIL claim1_id got=%0h exp=3", claimId); end
    regAddr = 2'd3; #1;
    total++; if (regReadData !== 8'h04) begin bad++; $display("FAIL claim1_insvc got=%0h exp=04", regReadData); end
    regAddr = 2'd2; #1;
    total++; if (regReadData !== 8'h10) begin bad++; $display("FAIL claim1_pend got=%0h exp=10", regReadData); end
    cycle();
    claimReq = 1'b0;
    total++; if (claimId !== 4'd5) begin bad++; $display("FAIL claim2_id got=%0h exp=5", claimId); end
    regAddr = 2'd3; #1;
    total++; if (regReadData !== 8'h14) begin bad++; $display("FAIL claim2_insvc got=%0h exp=14", regReadData); end
    cycle();
    total++; if (claimValid !== 1'b0) begin bad++; $display("FAIL claim_pulse got=%0h exp=0", claimValid); end
    total++; if (claimId !== 4'd5) begin bad++; $display("FAIL claim_hold got=%0h exp=5", claimId); end
  endtask

  task automatic test_empty_claim();
    doReset();
    irqIn = 8'h01;
    cycle();
    claimReq = 1'b1;
    cycle();
    claimReq = 1'b0;
    total++; if (claimValid !== 1'b1) begin bad++; $display("FAIL empty_valid got=%0h exp=1", claimValid); end
    total++; if (claimId !== 4'd0) begin bad++; $display("FAIL empty_id got=%0h exp=0", claimId); end
    regAddr = 2'd2; #1;
    total++; if (regReadData !== 8'h01) begin bad++; $display("FAIL empty_pend got=%0h exp=01", regReadData); end
    regAddr = 2'd3; #1;
    total++; if (regReadData !== 8'h00) begin bad++; $display("FAIL empty_insvc got=%0h exp=00", regReadData); end
  endtask

  task automatic test_complete_level();
    doReset();
    writeReg(2'd0, 8'hFF);
    irqIn = 8'h02;
    cycle(); cycle();
    claimReq = 1'b1;
    cycle();
    claimReq = 1'b0;
    total++; if (claimId !== 4'd2) begin bad++; $display("FAIL cpl_claim got=%0h exp=2", claimId); end
    cycle();
    total++; if (externalInterrupt !== 1'b0) begin bad++; $display("FAIL cpl_ext_claimed got=%0h exp=0", externalInterrupt); end
    completeReq = 1'b1; completeId = 4'd2;
    cycle();
    completeReq = 1'b0;
    regAddr = 2'd3; #1;
    total++; if (regReadData !== 8'h00) begin bad++; $display("FAIL cpl_insvc got=%0h exp=00", regReadData); end
    regAddr = 2'd2; #1;
    total++; if (regReadData !== 8'h00) begin bad++; $display("FAIL cpl_pend_t1 got=%0h exp=00", regReadData); end
    cycle();
    total++; if (regReadData !== 8'h02) begin bad++; $display("FAIL cpl_pend_t2 got=%0h exp=02", regReadData); end
    total++; if (externalInterrupt !== 1'b0) begin bad++; $display("FAIL cpl_ext_t2 got=%0h exp=0", externalInterrupt); end
    cycle();
    total++; if (externalInterrupt !== 1'b1 || externalInterruptCode !== 4'd2) begin
      bad++; $display("FAIL cpl_ext_t3 got=%0h/%0h exp=1/2", externalInterrupt, externalInterruptCode); end
    claimReq = 1'b1;
    cycle();
    claimReq = 1'b0;
    completeReq = 1'b1; completeId = 4'd7;
    cycle();
    completeReq = 1'b0;
    regAddr = 2'd3; #1;
    total++; if (regReadData !== 8'h02) begin bad++; $display("FAIL cpl_bad_id got=%0h exp=02", regReadData); end
  endtask

  task automatic test_edge_in_service();
    doReset();
    writeReg(2'd0, 8'hFF);
    writeReg(2'd1, 8'h08);
    irqIn = 8'h08;
    cycle();
    irqIn = 8'h00;
    cycle();
    total++; if (externalInterruptCode !== 4'd4) begin bad++; $display("FAIL eis_code got=%0h exp=4", externalInterruptCode); end
    claimReq = 1'b1;
    cycle();
    claimReq = 1'b0;
    total++; if (claimId !== 4'd4) begin bad++; $display("FAIL eis_claim got=%0h exp=4", claimId); end
    cycle();
    irqIn = 8'h08;
    cycle();
    irqIn = 8'h00;
    regAddr = 2'd2; #1;
    total++; if (regReadData !== 8'h08) begin bad++; $display("FAIL eis_pend got=%0h exp=08", regReadData); end
    cycle(); cycle();
    total++; if (externalInterrupt !== 1'b0) begin bad++; $display("FAIL eis_masked got=%0h exp=0", externalInterrupt); end
    completeReq = 1'b1; completeId = 4'd4;
    cycle();
    completeReq = 1'b0;
    cycle();
    total++; if (externalInterrupt !== 1'b1 || externalInterruptCode !== 4'd4) begin
      bad++; $display("FAIL eis_reassert got=%0h/%0h exp=1/4", externalInterrupt, externalInterruptCode); end
  endtask

  task automatic test_mask();
    doReset();
    writeReg(2'd0, 8'hFF);
    irqIn = 8'h22;
    cycle(); cycle();
    total++; if (externalInterruptCode !== 4'd2) begin bad++; $display("FAIL mask_base got=%0h exp=2", externalInterruptCode); end
    writeReg(2'd0, 8'hFD);
    cycle();
    total++; if (externalInterruptCode !== 4'd6) begin bad++; $display("FAIL mask_next got=%0h exp=6", externalInterruptCode); end
    regAddr = 2'd2; #1;
    total++; if (regReadData !== 8'h22) begin bad++; $display("FAIL mask_pend got=%0h exp=22", regReadData); end
    writeReg(2'd0, 8'h00);
    cycle();
    total++; if (externalInterrupt !== 1'b0 || externalInterruptCode !== 4'd0) begin
      bad++; $display("FAIL mask_none got=%0h/%0h exp=0/0", externalInterrupt, externalInterruptCode); end
    writeReg(2'd0, 8'hFF);
    cycle();
    total++; if (externalInterruptCode !== 4'd2) begin bad++; $display("FAIL mask_restore got=%0h exp=2", externalInterruptCode); end
  endtask

  task automatic test_async_reset();
    doReset();
    writeReg(2'd0, 8'hFF);
    irqIn = 8'h01;
    cycle(); cycle();
    claimReq = 1'b1;
    cycle();
    claimReq = 1'b0;
    total++; if (claimValid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0h exp=1", claimValid); end
    #2 rst = 1'b1;
    #1;
    total++; if (claimValid !== 1'b0 || claimId !== 4'd0) begin
      bad++; $display("FAIL arst_claim got=%0h/%0h exp=0/0", claimValid, claimId); end
    total++; if (externalInterrupt !== 1'b0 || externalInterruptCode !== 4'd0) begin
      bad++; $display("FAIL arst_ext got=%0h/%0h exp=0/0", externalInterrupt, externalInterruptCode); end
    regAddr = 2'd3; #1;
    total++; if (regReadData !== 8'h00) begin bad++; $display("FAIL arst_insvc got=%0h exp=00", regReadData); end
    irqIn = '0;
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    int b;
    doReset();
    writeReg(2'd0, 8'hFF);
    for (int n = 0; n < 3000; n++) begin
      total++; if (claimValid !== mClaimValid) begin bad++; $display("FAIL rnd_claimValid n=%0d got=%0h exp=%0h", n, claimValid, mClaimValid); end
      total++; if (claimId !== CW'(mClaimId)) begin bad++; $display("FAIL rnd_claimId n=%0d got=%0h exp=%0h", n, claimId, mClaimId); end
      total++; if (externalInterrupt !== mExt) begin bad++; $display("FAIL rnd_ext n=%0d got=%0h exp=%0h", n, externalInterrupt, mExt); end
      total++; if (externalInterruptCode !== CW'(mCode)) begin bad++; $display("FAIL rnd_code n=%0d got=%0h exp=%0h", n, externalInterruptCode, mCode); end
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, NS - 1);
        irqIn[b] = ~irqIn[b];
      end
      claimReq     = ($urandom_range(0, 3) == 0);
      completeReq  = ($urandom_range(0, 2) == 0);
      completeId   = CW'($urandom_range(0, 10));
      regWE        = ($urandom_range(0, 19) == 0);
      regAddr      = 2'($urandom_range(0, 3));
      regWriteData = NS'($urandom);
      #1;
      total++; if (regReadData !== modelReg(regAddr)) begin
        bad++; $display("FAIL rnd_reg n=%0d addr=%0d got=%0h exp=%0h", n, regAddr, regReadData, modelReg(regAddr)); end
      cycle();
    end
    regWE = 1'b0; claimReq = 1'b0; completeReq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_pulse();
    test_claim_level();
    test_empty_claim();
    test_complete_level();
    test_edge_in_service();
    test_mask();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
